nb_score_compare: RTL and testbench

Decision stage directly downstream of the MAC in the Naive Bayes ham/spam classifier. It sequences the MAC through two accumulation passes, ham log-likelihood then spam log-likelihood. It pulses the MAC clear between passes, captures each final 36-bit accumulated score and adds the per-class log prior. It then compares the two totals and reports the class with a registered done pulse.

---
 rtl/nb_pkg.sv | 16 +
 rtl/nb_beat_counter.sv | 38 +++
 rtl/nb_score_compare.sv | 174 +++++++++++++++++
 tb/tb_nb_score_compare.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nb_pkg.sv
// Shared definitions for the Naive Bayes score-compare stage.
package nb_pkg;

    localparam int ACC_W_DEF   = 36;
    localparam int PRIOR_W_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR_H  = 3'd1,
        ST_HAM    = 3'd2,
        ST_CLR_S  = 3'd3,
        ST_SPAM   = 3'd4,
        ST_DECIDE = 3'd5
    } nb_state_e;

endpackage

// File: rtl/nb_beat_counter.sv
// Per-pass beat counter: clear, increment on valid, flag on the final beat of a pass.
module nb_beat_counter #(
    parameter int N_TERMS = 16,
    parameter int CW      = $clog2(N_TERMS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted combinationally with the beat that completes the pass.
    assign last = inc && (cnt_q == CW'(N_TERMS - 1));
    assign cnt  = cnt_q;

endmodule

// File: rtl/nb_score_compare.sv
// Ham/spam decision stage: runs two MAC passes, adds log priors, reports the class.
// Optional watchdog abort is built when NB_TIMEOUT_EN is defined.
import nb_pkg::*;

module nb_score_compare #(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PRIOR_W = PRIOR_W_DEF,
    parameter int N_TERMS = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic signed [ACC_W-1:0]           acc_in,
    input  logic                              acc_valid,
    input  logic signed [PRIOR_W-1:0]         prior_ham,
    input  logic signed [PRIOR_W-1:0]         prior_spam,
    output logic                              mac_clear,
    output logic                              busy,
    output logic                              done,
    output logic                              is_spam,
    output logic signed [ACC_W+1:0]           margin,
    output logic [$clog2(N_TERMS+1)-1:0]      term_cnt,
    output logic                              err
);

    // state     | meaning
    // IDLE      | waiting for start
    // CLR_H     | one-cycle MAC clear before the ham pass
    // HAM       | counting ham beats, latch score on the last one
    // CLR_S     | one-cycle MAC clear before the spam pass
    // SPAM      | counting spam beats, latch score on the last one
    // DECIDE    | add priors, compare totals, register result

    localparam int CW = $clog2(N_TERMS + 1);
    localparam int MW = ACC_W + 2;

    nb_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] ham_q, ham_d;
    logic signed [ACC_W-1:0] spam_q, spam_d;
    logic signed [MW-1:0]    margin_q, margin_d;
    logic                    is_spam_q, is_spam_d;
    logic                    done_q, done_d;

    logic                    in_pass;
    logic                    cnt_clr;
    logic                    cnt_last;
    logic                    wd_expire;
    logic signed [MW-1:0]    ham_total;
    logic signed [MW-1:0]    spam_total;
    logic signed [MW-1:0]    margin_sum;

    assign in_pass = (state_q == ST_HAM) || (state_q == ST_SPAM);
    assign cnt_clr = (state_d == ST_CLR_H) || (state_d == ST_CLR_S);

    nb_beat_counter #(
        .N_TERMS (N_TERMS),
        .CW      (CW)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (in_pass && acc_valid),
        .cnt   (term_cnt),
        .last  (cnt_last)
    );

    // Two guard bits make the sum and difference exact for any operand values.
    assign ham_total  = {{2{ham_q[ACC_W-1]}}, ham_q}
                      + {{(MW-PRIOR_W){prior_ham[PRIOR_W-1]}}, prior_ham};
    assign spam_total = {{2{spam_q[ACC_W-1]}}, spam_q}
                      + {{(MW-PRIOR_W){prior_spam[PRIOR_W-1]}}, prior_spam};
    assign margin_sum = spam_total - ham_total;

    always_comb begin
        state_d   = state_q;
        ham_d     = ham_q;
        spam_d    = spam_q;
        margin_d  = margin_q;
        is_spam_d = is_spam_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR_H;
                end
            end
            ST_CLR_H: state_d = ST_HAM;
            ST_HAM: begin
                if (cnt_last) begin
                    ham_d   = acc_in;
                    state_d = ST_CLR_S;
                end
            end
            ST_CLR_S: state_d = ST_SPAM;
            ST_SPAM: begin
                if (cnt_last) begin
                    spam_d  = acc_in;
                    state_d = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                margin_d  = margin_sum;
                is_spam_d = !margin_sum[MW-1] && (margin_sum != '0);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_expire) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ham_q     <= '0;
            spam_q    <= '0;
            margin_q  <= '0;
            is_spam_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ham_q     <= ham_d;
            spam_q    <= spam_d;
            margin_q  <= margin_d;
            is_spam_q <= is_spam_d;
            done_q    <= done_d;
        end
    end

`ifdef NB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          err_q;

    // Counts consecutive idle cycles inside a pass; any beat restarts it.
    always_comb begin
        wd_d      = '0;
        wd_expire = 1'b0;
        if (in_pass && !acc_valid) begin
            if (wd_q == WW'(TIMEOUT - 1)) begin
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= wd_expire;
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    assign mac_clear = (state_q == ST_CLR_H) || (state_q == ST_CLR_S);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign is_spam   = is_spam_q;
    assign margin    = margin_q;

endmodule

// File: tb/tb_nb_score_compare.sv
// Directed bench for nb_score_compare; the watchdog sequence is built with NB_TIMEOUT_EN.
module tb_nb_score_compare;

    localparam int ACC_W   = 36;
    localparam int PRIOR_W = 20;
    localparam int N_TERMS = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(N_TERMS + 1);
    localparam int MW      = ACC_W + 2;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic signed [ACC_W-1:0]   acc_in;
    logic                      acc_valid;
    logic signed [PRIOR_W-1:0] prior_ham;
    logic signed [PRIOR_W-1:0] prior_spam;
    logic                      mac_clear;
    logic                      busy;
    logic                      done;
    logic                      is_spam;
    logic signed [MW-1:0]      margin;
    logic [CW-1:0]             term_cnt;
    logic                      err;

    nb_score_compare #(
        .ACC_W   (ACC_W),
        .PRIOR_W (PRIOR_W),
        .N_TERMS (N_TERMS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .prior_ham  (prior_ham),
        .prior_spam (prior_spam),
        .mac_clear  (mac_clear),
        .busy       (busy),
        .done       (done),
        .is_spam    (is_spam),
        .margin     (margin),
        .term_cnt   (term_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [ACC_W-1:0]   ham;
        logic signed [ACC_W-1:0]   spam;
        logic signed [PRIOR_W-1:0] ph;
        logic signed [PRIOR_W-1:0] ps;
        logic                      exp_spam;
        logic signed [MW-1:0]      exp_margin;
    } vec_t;

    vec_t vecs [5];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   clr_cnt = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (mac_clear) clr_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Drives one pass of N_TERMS beats; leaves the DUT in CLR_S (ham) or DECIDE (spam).
    task automatic do_pass(input logic signed [ACC_W-1:0] final_val, input bit gaps);
        int g;
        for (int i = 0; i < N_TERMS; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k < g; k++) begin
                acc_valid = 1'b0;
                acc_in    = ACC_W'(-12345);
                tick();
                check("term_cnt_gap", 64'(term_cnt), 64'(i));
            end
            acc_valid = 1'b1;
            acc_in    = (i == N_TERMS - 1) ? final_val : ACC_W'(i * 1111 + 7);
            tick();
            acc_valid = 1'b0;
            if (i < N_TERMS - 1) check("term_cnt_beat", 64'(term_cnt), 64'(i + 1));
        end
    endtask

    task automatic run_class(input vec_t v, input bit gaps, input bit poke);
        int clr0;
        clr0       = clr_cnt;
        prior_ham  = v.ph;
        prior_spam = v.ps;
        start      = 1'b1;
        tick();
        start = poke;
        check("clr_h_mac_clear", 64'(mac_clear), 64'(1));
        check("clr_h_done_low", 64'(done), 64'(0));
        check("clr_h_term_cnt", 64'(term_cnt), 64'(0));
        tick();
        do_pass(v.ham, gaps);
        check("clr_s_mac_clear", 64'(mac_clear), 64'(1));
        check("clr_s_term_cnt", 64'(term_cnt), 64'(0));
        tick();
        do_pass(v.spam, gaps);
        check("decide_term_cnt", 64'(term_cnt), 64'(N_TERMS));
        check("decide_busy", 64'(busy), 64'(1));
        check("decide_done_low", 64'(done), 64'(0));
        start = 1'b0;
        tick();
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(0));
        check("is_spam", 64'(is_spam), 64'(v.exp_spam));
        check("margin", 64'(margin), 64'(v.exp_margin));
        check("err_low", 64'(err), 64'(0));
        check("mac_clear_cycles", 64'(clr_cnt - clr0), 64'(2));
    endtask

    initial begin
        int d0;
        vecs[0] = '{-36'sd1000, -36'sd1200, 20'sd0, 20'sd0, 1'b0, -38'sd200};
        vecs[1] = '{-36'sd1000, -36'sd900, -20'sd50, -20'sd50, 1'b1, 38'sd100};
        vecs[2] = '{-36'sd500, -36'sd480, -20'sd10, -20'sd30, 1'b0, 38'sd0};
        vecs[3] = '{36'sh8_0000_0000, 36'sh7_FFFF_FFFF, 20'sh80000, 20'sh7FFFF,
                    1'b1, 38'sh10_000F_FFFE};
        vecs[4] = '{36'sd100, -36'sd100, -20'sd30, 20'sd20, 1'b0, -38'sd150};

        reset      = 1'b0;
        start      = 1'b0;
        acc_in     = '0;
        acc_valid  = 1'b0;
        prior_ham  = '0;
        prior_spam = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mac_clear", 64'(mac_clear), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_is_spam", 64'(is_spam), 64'(0));
        check("rst_margin", 64'(margin), 64'(0));
        check("rst_term_cnt", 64'(term_cnt), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        reset = 1'b1;
        tick();

        // Back-to-back: each start is raised in the cycle done is high.
        for (int i = 0; i < 5; i++) begin
            run_class(vecs[i], i > 0, 1'b0);
        end

        // Reset while the second spam beat is sampled.
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        do_pass(-36'sd777, 1'b0);
        tick();
        acc_valid = 1'b1;
        acc_in    = 36'sd5;
        tick();
        check("spam_beat1_cnt", 64'(term_cnt), 64'(1));
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        acc_valid = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_mac_clear", 64'(mac_clear), 64'(0));
        check("midrst_term_cnt", 64'(term_cnt), 64'(0));
        check("midrst_margin", 64'(margin), 64'(0));
        check("midrst_is_spam", 64'(is_spam), 64'(0));
        tick();
        tick();
        check("midrst_no_done", 64'(done_cnt - d0), 64'(0));
        check("midrst_idle", 64'(busy), 64'(0));

        // Full run with start held high while busy; must not queue.
        run_class(vecs[1], 1'b1, 1'b1);
        tick();
        check("no_queued_start", 64'(busy), 64'(0));

`ifdef NB_TIMEOUT_EN
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        acc_valid = 1'b1;
        acc_in    = 36'sd9;
        tick();
        acc_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k < TIMEOUT) begin
                check("wd_err_low", 64'(err), 64'(0));
                check("wd_busy", 64'(busy), 64'(1));
            end else begin
                check("wd_err_pulse", 64'(err), 64'(1));
                check("wd_idle", 64'(busy), 64'(0));
            end
        end
        tick();
        check("wd_err_one_cycle", 64'(err), 64'(0));
        check("wd_margin_kept", 64'(margin), 64'(vecs[1].exp_margin));
        check("wd_is_spam_kept", 64'(is_spam), 64'(vecs[1].exp_spam));
        check("wd_no_done", 64'(done_cnt - d0), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
